// File: rtl/motor_drv_pkg.sv
// =============================================================================
// motor_drv_pkg : shared types and helpers for the two-motor drive stage
// Revision 1.0
// =============================================================================
`default_nettype none

package motor_drv_pkg;

    localparam int              DUTY_W   = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEAD   = 3'd1,
        RAMP   = 3'd2,
        RUN    = 3'd3,
        RAMPDN = 3'd4
    } drv_state_t;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } motor_sel_t;

    // Bits needed for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int clamp_min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/motor_drive_interlock_pwm.sv
// =============================================================================
// motor_pwm_gen : free-running prescaler + 8-bit frame counter, registered PWM
// Revision 1.0
// =============================================================================
`default_nettype none

module motor_pwm_gen
    import motor_drv_pkg::*;
#(
    parameter int PRE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_o
);

    localparam int               PRE_W    = width_for(PRE_CYC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CYC - 1);

    logic [PRE_W-1:0]  pre_q;
    logic [DUTY_W-1:0] pc_q;
    logic              pwm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            pc_q  <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                pc_q  <= pc_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            // Full duty forces a constant high; otherwise compare against the frame position.
            pwm_q <= en_i & ((duty_i == DUTY_MAX) | (pc_q < duty_i));
        end
    end

    assign pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/motor_drive_interlock.sv
// =============================================================================
// motor_drive_interlock : dead-time, soft-start and interlocked gate drive for
// two alternating motors. Optional soft stop: define MOTOR_DRV_SOFTSTOP_EN.
// Revision 1.0
// =============================================================================
`default_nettype none

module motor_drive_interlock
    import motor_drv_pkg::*;
#(
    parameter int F_CLK_HZ = 25_000_000,
    parameter int PWM_HZ   = 1_000,
    parameter int DEAD_MS  = 500,
    parameter int RAMP_MS  = 1_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_m1,
    input  logic              req_m2,
    output logic              drv_m1,
    output logic              drv_m2,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              fault
);

    localparam int DEAD_CYC = clamp_min1(F_CLK_HZ / 1000 * DEAD_MS);
    localparam int STEP_CYC = clamp_min1(F_CLK_HZ / 1000 * RAMP_MS / 255);
    localparam int PWM_PRE  = clamp_min1(F_CLK_HZ / (PWM_HZ * 256));
    localparam int CNT_W    = width_for((DEAD_CYC > STEP_CYC) ? DEAD_CYC : STEP_CYC);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);

    drv_state_t        state_q, state_d;
    motor_sel_t        sel_q,   sel_d;
    logic [DUTY_W-1:0] duty_q,  duty_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              fault_q, busy_q;

    logic       w_both, w_want, w_sel_req, w_oth_req, w_drive_en, w_pwm;
    motor_sel_t w_tgt, w_oth;

    assign w_both    = req_m1 & req_m2;
    assign w_want    = req_m1 ^ req_m2;
    assign w_tgt     = motor_sel_t'(req_m2);
    assign w_oth     = motor_sel_t'(sel_q == M1);
    assign w_sel_req = (sel_q == M1) ? req_m1 : req_m2;
    assign w_oth_req = (sel_q == M1) ? req_m2 : req_m1;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        duty_d  = duty_q;
        cnt_d   = cnt_q;
        if (w_both) begin
            state_d = IDLE;
            duty_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_want) begin
                        sel_d   = w_tgt;
                        cnt_d   = '0;
                        state_d = DEAD;
                    end
                end
                DEAD: begin
                    if (!w_want) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (w_tgt != sel_q) begin
                        sel_d = w_tgt;
                        cnt_d = '0;
                    end else if (cnt_q == DEAD_LAST) begin
                        state_d = RAMP;
                        duty_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RAMP, RUN: begin
                    if (!w_sel_req) begin
`ifdef MOTOR_DRV_SOFTSTOP_EN
                        state_d = RAMPDN;
                        cnt_d   = '0;
`else
                        duty_d = '0;
                        cnt_d  = '0;
                        if (w_oth_req) begin
                            sel_d   = w_oth;
                            state_d = DEAD;
                        end else begin
                            state_d = IDLE;
                        end
`endif
                    end else if (state_q == RAMP) begin
                        if (duty_q == DUTY_MAX) begin
                            state_d = RUN;
                        end else if (cnt_q == STEP_LAST) begin
                            cnt_d  = '0;
                            duty_d = duty_q + 1'b1;
                            if (duty_q == DUTY_MAX - 1'b1) begin
                                state_d = RUN;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`ifdef MOTOR_DRV_SOFTSTOP_EN
                RAMPDN: begin
                    if (w_sel_req) begin
                        cnt_d = '0;
                        if (duty_q == DUTY_MAX) begin
                            state_d = RUN;
                        end else begin
                            state_d = RAMP;
                        end
                    end else if ((duty_q == '0) ||
                                 ((cnt_q == STEP_LAST) && (duty_q == DUTY_W'(1)))) begin
                        // Ramp-down finished: hand over through a fresh dead time.
                        duty_d = '0;
                        cnt_d  = '0;
                        if (w_oth_req) begin
                            sel_d   = w_oth;
                            state_d = DEAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (cnt_q == STEP_LAST) begin
                        cnt_d  = '0;
                        duty_d = duty_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= M1;
            duty_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_d;
            fault_q <= w_both;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Gating from next-state values makes a drop or fault kill the drive on the very next edge.
    assign w_drive_en = (state_d == RAMP) | (state_d == RUN) | (state_d == RAMPDN);

    motor_pwm_gen #(
        .PRE_CYC (PWM_PRE)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_drive_en),
        .duty_i (duty_d),
        .pwm_o  (w_pwm)
    );

    // A single registered PWM routed by a single registered select cannot reach both motors.
    assign drv_m1 = w_pwm & (sel_q == M1);
    assign drv_m2 = w_pwm & (sel_q == M2);
    assign duty   = duty_q;
    assign busy   = busy_q;
    assign fault  = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_drive_interlock.sv
// =============================================================================
// tb_motor_drive_interlock : randomized scoreboard bench against a cycle-level
// behavioural model of the drive stage (default build).
// Revision 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_motor_drive_interlock;

    localparam int DEAD_CYC = 10;
    localparam int STEP_CYC = 1;
    localparam int PWM_PRE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_m1 = 1'b0;
    logic       req_m2 = 1'b0;
    logic       drv_m1, drv_m2, busy, fault;
    logic [7:0] duty;

    always #5 clk = ~clk;

    motor_drive_interlock #(
        .F_CLK_HZ (1000),
        .PWM_HZ   (1),
        .DEAD_MS  (10),
        .RAMP_MS  (255)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .req_m1 (req_m1),
        .req_m2 (req_m2),
        .drv_m1 (drv_m1),
        .drv_m2 (drv_m2),
        .duty   (duty),
        .busy   (busy),
        .fault  (fault)
    );

    typedef struct packed {
        logic       d1;
        logic       d2;
        logic [7:0] duty;
        logic       busy;
        logic       fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: phase 0 = off, 1 = waiting out dead time, 2 = energised
    int m_phase, m_sel, m_elapsed, m_duty, m_edges;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_sel = 1; m_elapsed = 0; m_duty = 0; m_edges = 0;
    endtask

    task automatic model_step(input bit r1, input bit r2, output exp_t e);
        int  pc;
        int  want_sel;
        bit  want, sreq, oreq, on;
        pc = (m_edges / PWM_PRE) % 256;
        m_edges++;
        want     = r1 ^ r2;
        want_sel = r2 ? 2 : 1;
        if (r1 && r2) begin
            m_phase = 0;
            m_duty  = 0;
        end else if (m_phase == 0) begin
            if (want) begin
                m_sel = want_sel; m_elapsed = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!want) begin
                m_phase = 0;
            end else if (want_sel != m_sel) begin
                m_sel = want_sel; m_elapsed = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == DEAD_CYC) begin
                    m_phase = 2; m_duty = 0; m_elapsed = 0;
                end
            end
        end else begin
            sreq = (m_sel == 1) ? r1 : r2;
            oreq = (m_sel == 1) ? r2 : r1;
            if (!sreq) begin
                m_duty = 0;
                if (oreq) begin
                    m_sel = 3 - m_sel; m_phase = 1; m_elapsed = 0;
                end else begin
                    m_phase = 0;
                end
            end else if (m_duty < 255) begin
                m_elapsed++;
                if (m_elapsed == STEP_CYC) begin
                    m_duty++; m_elapsed = 0;
                end
            end
        end
        on      = (m_phase == 2) && ((m_duty == 255) || (pc < m_duty));
        e.d1    = on && (m_sel == 1);
        e.d2    = on && (m_sel == 2);
        e.duty  = 8'(m_duty);
        e.busy  = (m_phase != 0);
        e.fault = r1 && r2;
    endtask

    // Called at a falling edge: apply inputs, predict the next edge, wait one cycle.
    task automatic drive(input bit r1, input bit r2);
        exp_t e;
        req_m1 = r1;
        req_m2 = r2;
        model_step(r1, r2, e);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input bit r1, input bit r2, input int n);
        for (int i = 0; i < n; i++) drive(r1, r2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " drv_m1"}, int'(drv_m1), 0);
        check({tag, " drv_m2"}, int'(drv_m2), 0);
        check({tag, " duty"},   int'(duty),   0);
        check({tag, " busy"},   int'(busy),   0);
        check({tag, " fault"},  int'(fault),  0);
    endtask

    // Asynchronous reset between edges; inputs keep their current values.
    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("drv_m1",    int'(drv_m1),          int'(e.d1));
                check("drv_m2",    int'(drv_m2),          int'(e.d2));
                check("duty",      int'(duty),            int'(e.duty));
                check("busy",      int'(busy),            int'(e.busy));
                check("fault",     int'(fault),           int'(e.fault));
                check("interlock", int'(drv_m1 & drv_m2), 0);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int kind, len;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;

        hold(1'b1, 1'b0, 300);   // start M1, through dead time and ramp into full duty
        hold(1'b0, 1'b1, 300);   // direct switch to M2
        hold(1'b1, 1'b1, 3);     // fault while M2 runs
        hold(1'b1, 1'b0, 100);   // release: M1 restarts with full dead time, now mid-ramp
        reset_pulse();
        hold(1'b1, 1'b0, 40);
        hold(1'b0, 1'b0, 5);

        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: hold(1'b0, 1'b0, $urandom_range(1, 20));
                1: hold(1'b1, 1'b0, $urandom_range(1, 320));
                2: hold(1'b0, 1'b1, $urandom_range(1, 320));
                3: hold(1'b1, 1'b1, $urandom_range(1, 3));
                default: begin
                    len = $urandom_range(10, 40);
                    for (int i = 0; i < len; i++) drive(1'($urandom), 1'($urandom));
                end
            endcase
            if ($urandom_range(0, 15) == 0) reset_pulse();
        end

        hold(1'b0, 1'b0, 3);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
